reg_scoreboard: RTL and testbench
=================================

// Module: reg_scoreboard
// PURPOSE
//  Issue-side hazard scheduler for the dual-issue GPR file (2 issue slots, 2 write ports).
//  Tracks pending writes per architectural register and gates issue of each slot until
//  all enabled sources are free. Resolves intra-pair RAW/WAW dependencies.
//  Sits between decode/issue and execute; wb_* is fed from the regfile write-port drivers.
// PARAMETERS
//  NUM_REGS  32  architectural GPRs; r0 is never busy
//  CNT_W     2   width of per-register pending-write counter (max 2**CNT_W-1 = 3)
//  PERF_W    32  width of stall-cycle performance counter
// PORTS
//  clk           in   1       clock
//  rst           in   1       reset: synchronous, active-high
//  flush         in   1       pipeline flush; kills all in-flight writes
//  ex_ready      in   1       execute stage can accept this cycle
//  id_valid      in   2       [0]=slot0 valid, [1]=slot1 valid (slot1 younger)
//  id0_rs_en     in   2       slot0 source enables {rs2,rs1}
//  id0_rs1/rs2   in   5 each  slot0 source addresses
//  id0_we/id0_rd in   1/5     slot0 dest write-enable / address
//  id1_rs_en     in   2       slot1 source enables {rs2,rs1}
//  id1_rs1/rs2   in   5 each  slot1 source addresses
//  id1_we/id1_rd in   1/5     slot1 dest write-enable / address
//  wb_en         in   2       regfile write-port enables [0]=port1, [1]=port2
//  wb_addr1/2    in   5 each  regfile write addresses
//  issue_go      out  2       combinational: slot accepted this cycle
//  busy_vec      out  32      registered: bit i = cnt[i]!=0
//  stall_cycles  out  PERF_W  registered hazard-stall counter
//  sb_err        out  1       registered sticky: counter underflow seen
// BEHAVIOUR
//  Reset: all cnt=0, busy_vec=0, stall_cycles=0, sb_err=0. issue_go is combinational, 0 when rst=1.
//  hz(a,en) = en & a!=0 & cnt[a]!=0. full(rd,we) = we & rd!=0 & cnt[rd]==MAX.
//  issue_go[0] = id_valid[0] & ex_ready & !flush & !rst & !hz(rs1/rs2 of slot0) & !full(slot0).
//  issue_go[1] = issue_go[0] & id_valid[1] & !hz(slot1 srcs) & !full(slot1)
//    & !(id0_we & id0_rd!=0 & slot1 enabled src == id0_rd)   (intra-pair RAW)
//    & !(id0_we & id1_we & id0_rd==id1_rd & id1_rd!=0).      (intra-pair WAW)
//  Slot1 never issues without slot0 (in-order); slot0 alone may issue.
//  Hazard checks use current-cycle cnt only: a wb in cycle N unblocks issue in N+1 (no same-cycle bypass).
//  Per-register update each cycle: cnt' = cnt + inc - dec.
//    inc = number of issued slots with we & rd==i & i!=0 (0..1, WAW rule bars 2).
//    dec = number of wb ports with wb_en & addr==i & i!=0 (0..2; both ports same addr -> 2).
//    issue + wb on same reg in same cycle -> net value; full() is evaluated pre-update.
//    dec > cnt+inc: clamp cnt' to 0, set sb_err (stays 1 until rst).
//  flush=1: issue_go=0, all cnt' = 0 regardless of wb_en; sb_err untouched.
//  rst overrides flush; rst mid-operation discards all pending state next cycle.
//  stall_cycles += 1 when id_valid[0] & ex_ready & !flush & !issue_go[0]; saturates at all-ones.
//  busy_vec reflects registered cnt (one cycle after the update that changes it).
// TESTING
//  T1 reset: rst 2 cycles -> busy_vec=0, stall_cycles=0, sb_err=0, issue_go=0.
//  T2 RAW stall: issue slot0 we rd=5; next cycle slot0 rs1=5 en -> issue_go=00, stall_cycles+1;
//     wb_en=01 addr1=5 -> issue_go=01 following cycle, busy_vec[5]=0.
//  T3 pair deps: slot0 we rd=7, slot1 rs2=7 en -> issue_go=01; slot1 we rd=7 (WAW) -> 01;
//     independent slot1 -> 11, cnt[7]=1.
//  T4 saturation: 3 issues to rd=9 without wb -> 4th blocked (issue_go[0]=0);
//     double wb addr1=addr2=9 -> cnt[9]=1.
//  T5 flush/err: busy on r3,r4 then flush=1 -> busy_vec=0 next cycle, issue_go=00 during flush;
//     later wb to r3 with cnt=0 -> sb_err=1, cnt stays 0.
//  T6 r0: slot0 we rd=0, slot1 rs1=0 en -> issue_go=11, busy_vec[0]=0 always.

Source files
------------

// File: rtl/reg_scoreboard.sv
// -----------------------------------------------------------------------------
// reg_scoreboard
// Issue-side hazard scheduler for a dual-issue GPR file (2 issue slots, 2 write
// ports). It keeps a pending-write counter for each architectural register and
// gates issue of each slot until all of that slot's enabled sources are free.
// It also resolves RAW and WAW dependencies within an issue pair.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   flush               kills every in-flight write (all counters cleared)
//   ex_ready            execute stage can accept this cycle
//   id_valid[1:0]       slot valids; slot1 is younger than slot0
//   id0_* / id1_*       per-slot source enables {rs2,rs1}, source addresses,
//                       destination write-enable and destination address
//   wb_en[1:0]          regfile write-port enables; [0] = port1, [1] = port2
//   wb_addr1/wb_addr2   regfile write-port addresses
//   issue_go[1:0]       combinational: slot accepted this cycle
//   busy_vec            registered: bit i set while register i has writes pending
//   stall_cycles        registered, saturating count of hazard-stall cycles
//   sb_err              registered, sticky: a counter underflow was seen
// -----------------------------------------------------------------------------
module reg_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int CNT_W    = 2,
    parameter int PERF_W   = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        ex_ready,
    input  logic [1:0]                  id_valid,
    input  logic [1:0]                  id0_rs_en,
    input  logic [$clog2(NUM_REGS)-1:0] id0_rs1,
    input  logic [$clog2(NUM_REGS)-1:0] id0_rs2,
    input  logic                        id0_we,
    input  logic [$clog2(NUM_REGS)-1:0] id0_rd,
    input  logic [1:0]                  id1_rs_en,
    input  logic [$clog2(NUM_REGS)-1:0] id1_rs1,
    input  logic [$clog2(NUM_REGS)-1:0] id1_rs2,
    input  logic                        id1_we,
    input  logic [$clog2(NUM_REGS)-1:0] id1_rd,
    input  logic [1:0]                  wb_en,
    input  logic [$clog2(NUM_REGS)-1:0] wb_addr1,
    input  logic [$clog2(NUM_REGS)-1:0] wb_addr2,
    output logic [1:0]                  issue_go,
    output logic [NUM_REGS-1:0]         busy_vec,
    output logic [PERF_W-1:0]           stall_cycles,
    output logic                        sb_err
);

    localparam int AW = $clog2(NUM_REGS);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0]    cnt_r [NUM_REGS];
    logic [CNT_W-1:0]    cnt_nxt_s [NUM_REGS];
    logic [NUM_REGS-1:0] busy_nxt_s;
    logic [NUM_REGS-1:0] busy_vec_r;
    logic [PERF_W-1:0]   stall_cycles_r;
    logic                sb_err_r;
    logic                underflow_s;
    logic                stall_inc_s;
    logic                hz0_s;
    logic                hz1_s;
    logic                full0_s;
    logic                full1_s;
    logic                raw_s;
    logic                waw_s;
    logic [1:0]          issue_go_s;

    // Hazard detection and issue gating; uses only the current registered counts.
    always_comb begin
        hz0_s   = (id0_rs_en[0] && (id0_rs1 != AW'(0)) && (cnt_r[id0_rs1] != CNT_W'(0))) ||
                  (id0_rs_en[1] && (id0_rs2 != AW'(0)) && (cnt_r[id0_rs2] != CNT_W'(0)));
        hz1_s   = (id1_rs_en[0] && (id1_rs1 != AW'(0)) && (cnt_r[id1_rs1] != CNT_W'(0))) ||
                  (id1_rs_en[1] && (id1_rs2 != AW'(0)) && (cnt_r[id1_rs2] != CNT_W'(0)));
        full0_s = id0_we && (id0_rd != AW'(0)) && (cnt_r[id0_rd] == CNT_MAX);
        full1_s = id1_we && (id1_rd != AW'(0)) && (cnt_r[id1_rd] == CNT_MAX);
        // slot1 reading what the older slot0 writes in the same pair
        raw_s   = id0_we && (id0_rd != AW'(0)) &&
                  ((id1_rs_en[0] && (id1_rs1 == id0_rd)) || (id1_rs_en[1] && (id1_rs2 == id0_rd)));
        // both slots writing the same register would need an increment of 2
        waw_s   = id0_we && id1_we && (id0_rd == id1_rd) && (id1_rd != AW'(0));
        issue_go_s[0] = id_valid[0] && ex_ready && !flush && !rst && !hz0_s && !full0_s;
        issue_go_s[1] = issue_go_s[0] && id_valid[1] && !hz1_s && !full1_s && !raw_s && !waw_s;
        stall_inc_s   = id_valid[0] && ex_ready && !flush && !issue_go_s[0];
    end

    // Next pending-write counts: issue increments, writeback decrements, clamp on underflow.
    always_comb begin
        logic [CNT_W:0] inc_v;
        logic [CNT_W:0] dec_v;
        logic [CNT_W:0] sum_v;
        inc_v        = '0;
        dec_v        = '0;
        sum_v        = '0;
        underflow_s  = 1'b0;
        cnt_nxt_s[0] = '0;
        busy_nxt_s   = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            inc_v = (CNT_W+1)'(issue_go_s[0] && id0_we && (id0_rd == AW'(i))) +
                    (CNT_W+1)'(issue_go_s[1] && id1_we && (id1_rd == AW'(i)));
            dec_v = (CNT_W+1)'(wb_en[0] && (wb_addr1 == AW'(i))) +
                    (CNT_W+1)'(wb_en[1] && (wb_addr2 == AW'(i)));
            sum_v = {1'b0, cnt_r[i]} + inc_v;
            if (dec_v > sum_v) begin
                cnt_nxt_s[i] = '0;
                underflow_s  = 1'b1;
            end else begin
                cnt_nxt_s[i] = CNT_W'(sum_v - dec_v);
            end
            busy_nxt_s[i] = (cnt_nxt_s[i] != CNT_W'(0));
        end
    end

    // State update: reset beats flush, flush clears all pending writes but keeps sb_err.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                cnt_r[i] <= '0;
            end
            busy_vec_r     <= '0;
            stall_cycles_r <= '0;
            sb_err_r       <= 1'b0;
        end else if (flush) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                cnt_r[i] <= '0;
            end
            busy_vec_r <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                cnt_r[i] <= cnt_nxt_s[i];
            end
            busy_vec_r <= busy_nxt_s;
            if (underflow_s) begin
                sb_err_r <= 1'b1;
            end
            if (stall_inc_s && (stall_cycles_r != {PERF_W{1'b1}})) begin
                stall_cycles_r <= stall_cycles_r + PERF_W'(1);
            end
        end
    end

    assign issue_go     = issue_go_s;
    assign busy_vec     = busy_vec_r;
    assign stall_cycles = stall_cycles_r;
    assign sb_err       = sb_err_r;

endmodule

// File: tb/tb_reg_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_reg_scoreboard
// Directed-vector bench for reg_scoreboard. Expected values are worked out by
// hand for each vector. Inputs change 1 time unit after a rising edge. Outputs
// are sampled 1 time unit later, so they are read well away from the clock edge.
// -----------------------------------------------------------------------------
module tb_reg_scoreboard;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        ex_ready;
    logic [1:0]  id_valid;
    logic [1:0]  id0_rs_en;
    logic [4:0]  id0_rs1;
    logic [4:0]  id0_rs2;
    logic        id0_we;
    logic [4:0]  id0_rd;
    logic [1:0]  id1_rs_en;
    logic [4:0]  id1_rs1;
    logic [4:0]  id1_rs2;
    logic        id1_we;
    logic [4:0]  id1_rd;
    logic [1:0]  wb_en;
    logic [4:0]  wb_addr1;
    logic [4:0]  wb_addr2;
    logic [1:0]  issue_go;
    logic [31:0] busy_vec;
    logic [31:0] stall_cycles;
    logic        sb_err;

    int total_cnt = 0;
    int bad_cnt   = 0;

    reg_scoreboard dut (
        .clk(clk), .rst(rst), .flush(flush), .ex_ready(ex_ready), .id_valid(id_valid),
        .id0_rs_en(id0_rs_en), .id0_rs1(id0_rs1), .id0_rs2(id0_rs2),
        .id0_we(id0_we), .id0_rd(id0_rd),
        .id1_rs_en(id1_rs_en), .id1_rs1(id1_rs1), .id1_rs2(id1_rs2),
        .id1_we(id1_we), .id1_rd(id1_rd),
        .wb_en(wb_en), .wb_addr1(wb_addr1), .wb_addr2(wb_addr2),
        .issue_go(issue_go), .busy_vec(busy_vec),
        .stall_cycles(stall_cycles), .sb_err(sb_err)
    );

    // 10-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // let combinational issue_go settle after an input change, then compare
    task automatic check_go(input string tag, input logic [1:0] exp);
        #1;
        check_val(tag, {30'd0, issue_go}, {30'd0, exp});
    endtask

    task automatic idle_in();
        flush = 1'b0; ex_ready = 1'b1; id_valid = 2'b00;
        id0_rs_en = 2'b00; id0_rs1 = 5'd0; id0_rs2 = 5'd0; id0_we = 1'b0; id0_rd = 5'd0;
        id1_rs_en = 2'b00; id1_rs1 = 5'd0; id1_rs2 = 5'd0; id1_we = 1'b0; id1_rd = 5'd0;
        wb_en = 2'b00; wb_addr1 = 5'd0; wb_addr2 = 5'd0;
    endtask

    initial begin
        rst = 1'b1;
        idle_in();
        // T1 reset
        tick(); tick();
        check_val("rst_busy", busy_vec, 32'h0);
        check_val("rst_stall", stall_cycles, 32'd0);
        check_val("rst_err", {31'd0, sb_err}, 32'd0);
        id_valid = 2'b01;
        check_go("rst_go", 2'b00);
        rst = 1'b0;
        idle_in();
        tick();

        // T2 RAW stall on r5, released by a writeback with no same-cycle bypass
        id_valid = 2'b01; id0_we = 1'b1; id0_rd = 5'd5;
        check_go("t2_issue", 2'b01);
        tick();
        check_val("t2_busy5", busy_vec, 32'h0000_0020);
        idle_in();
        id_valid = 2'b01; id0_rs_en = 2'b01; id0_rs1 = 5'd5;
        check_go("t2_raw", 2'b00);
        tick();
        check_val("t2_stall1", stall_cycles, 32'd1);
        wb_en = 2'b01; wb_addr1 = 5'd5;
        check_go("t2_nobypass", 2'b00);
        tick();
        check_val("t2_stall2", stall_cycles, 32'd2);
        check_val("t2_free", busy_vec, 32'h0);
        wb_en = 2'b00;
        check_go("t2_release", 2'b01);
        idle_in();
        tick();

        // T3 intra-pair RAW, WAW, then an independent pair
        id_valid = 2'b11; id0_we = 1'b1; id0_rd = 5'd7;
        id1_rs_en = 2'b10; id1_rs2 = 5'd7;
        check_go("t3_raw", 2'b01);
        id1_rs_en = 2'b00; id1_we = 1'b1; id1_rd = 5'd7;
        check_go("t3_waw", 2'b01);
        id1_rd = 5'd8;
        check_go("t3_indep", 2'b11);
        tick();
        check_val("t3_busy", busy_vec, 32'h0000_0180);
        idle_in();
        wb_en = 2'b11; wb_addr1 = 5'd7; wb_addr2 = 5'd8;
        tick();
        check_val("t3_clear", busy_vec, 32'h0);
        check_val("t3_err", {31'd0, sb_err}, 32'd0);
        idle_in();

        // T4 counter saturation on r9
        id_valid = 2'b01; id0_we = 1'b1; id0_rd = 5'd9;
        for (int k = 0; k < 3; k++) begin
            check_go($sformatf("t4_issue%0d", k), 2'b01);
            tick();
        end
        check_val("t4_busy9", busy_vec, 32'h0000_0200);
        check_go("t4_full", 2'b00);
        tick();
        check_val("t4_stall3", stall_cycles, 32'd3);
        idle_in();
        wb_en = 2'b11; wb_addr1 = 5'd9; wb_addr2 = 5'd9;
        tick();
        check_val("t4_dblwb", busy_vec, 32'h0000_0200);
        wb_en = 2'b01;
        tick();
        check_val("t4_last", busy_vec, 32'h0);
        check_val("t4_err", {31'd0, sb_err}, 32'd0);
        // ex_ready low: no issue and no stall count
        idle_in();
        ex_ready = 1'b0; id_valid = 2'b01;
        check_go("t4_notready", 2'b00);
        tick();
        check_val("t4_nostall", stall_cycles, 32'd3);
        idle_in();

        // T5 flush, then underflow
        id_valid = 2'b11; id0_we = 1'b1; id0_rd = 5'd3; id1_we = 1'b1; id1_rd = 5'd4;
        check_go("t5_pair", 2'b11);
        tick();
        check_val("t5_busy", busy_vec, 32'h0000_0018);
        flush = 1'b1; wb_en = 2'b01; wb_addr1 = 5'd3;
        check_go("t5_flushgo", 2'b00);
        tick();
        check_val("t5_flushed", busy_vec, 32'h0);
        check_val("t5_flstall", stall_cycles, 32'd3);
        check_val("t5_flerr", {31'd0, sb_err}, 32'd0);
        idle_in();
        wb_en = 2'b01; wb_addr1 = 5'd3;
        tick();
        check_val("t5_underflow", {31'd0, sb_err}, 32'd1);
        check_val("t5_clamp", busy_vec, 32'h0);
        idle_in();
        tick();
        check_val("t5_sticky", {31'd0, sb_err}, 32'd1);

        // T6 r0 is never busy and never a hazard
        id_valid = 2'b11; id0_we = 1'b1; id0_rd = 5'd0; id1_rs_en = 2'b01; id1_rs1 = 5'd0;
        check_go("t6_r0", 2'b11);
        tick();
        check_val("t6_busy0", busy_vec, 32'h0);
        idle_in();

        // reset in mid-operation discards pending state
        id_valid = 2'b01; id0_we = 1'b1; id0_rd = 5'd10;
        tick();
        check_val("rst2_busy10", busy_vec, 32'h0000_0400);
        idle_in();
        rst = 1'b1;
        tick();
        check_val("rst2_busy", busy_vec, 32'h0);
        check_val("rst2_err", {31'd0, sb_err}, 32'd0);
        check_val("rst2_stall", stall_cycles, 32'd0);
        rst = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
